// File: rtl/prog_inst_memory.sv
// Instruction memory: one-cycle registered fetch port plus a streaming program-load port.
// Fetches are served only while idle; the load FSM owns the memory while loading.
module prog_inst_memory #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 128,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                pc,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          inst,
  output logic                       inst_valid,
  output logic                       addr_err,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic                       ld_busy,
  output logic                       ld_done,
  output logic [$clog2(DEPTH):0]     ld_count,
  output logic [DATA_W-1:0]          ld_sum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] inst_q;
  logic              inst_valid_q;
  logic              addr_err_q;
  logic              ld_done_q;
  logic [CW-1:0]     ld_count_q;
  logic [CW-1:0]     ld_count_d;
  logic [DATA_W-1:0] ld_sum_q;
  logic [DATA_W-1:0] ld_sum_d;
  logic [31:0]       fetch_idx;
  logic              fetch_in_range;
  logic              wr_en;
  logic              wr_final;

  // Contents survive reset, so the array has a power-up value but no reset branch.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

  assign fetch_idx      = BYTE_ADDR ? {2'b00, pc[31:2]} : pc;
  assign fetch_in_range = (fetch_idx < DEPTH);
  assign wr_en          = (state_q == LOAD) && ld_valid;
  assign wr_final       = ld_last || (ld_count_q == CW'(DEPTH - 1));
  assign ld_count_d     = ld_count_q + CW'(1);
  assign ld_sum_d       = ld_sum_q ^ ld_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ld_count_q[AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      inst_q       <= NOP_WORD;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      ld_done_q    <= 1'b0;
      ld_count_q   <= '0;
      ld_sum_q     <= '0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_start) begin
            state_q    <= LOAD;
            ld_count_q <= '0;
            ld_sum_q   <= '0;
          end
          if (rd_en) begin
            if (fetch_in_range) begin
              inst_q       <= mem_q[fetch_idx[AW-1:0]];
              inst_valid_q <= 1'b1;
              addr_err_q   <= 1'b0;
            end else begin
              inst_q       <= NOP_WORD;
              inst_valid_q <= 1'b0;
              addr_err_q   <= 1'b1;
            end
          end
        end
        LOAD: begin
          // The fetch side is blanked every cycle the loader owns the memory.
          inst_q       <= NOP_WORD;
          inst_valid_q <= 1'b0;
          addr_err_q   <= 1'b0;
          if (ld_valid) begin
            ld_count_q <= ld_count_d;
            ld_sum_q   <= ld_sum_d;
            if (wr_final) begin
              state_q   <= IDLE;
              ld_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign ld_busy    = (state_q == LOAD);
  assign ld_ready   = ld_busy;
  assign ld_done    = ld_done_q;
  assign ld_count   = ld_count_q;
  assign ld_sum     = ld_sum_q;

endmodule
